// File: rtl/updown_timer_counter.sv
// Up/down timer/event counter with wrap, hold and auto-reload terminal modes.
// Keeps a reload register, a registered terminal-count pulse and a hold-mode done flag.
//
// state | meaning
// RUN   | counting allowed, done=0
// DONE  | parked at terminal in hold mode, done=1 until load_en
module updown_timer_counter #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load_en,
  input  logic [WIDTH-1:0] data,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  localparam logic RUN  = 1'b0;
  localparam logic DONE = 1'b1;

  localparam logic [1:0] MODE_WRAP   = 2'b00;
  localparam logic [1:0] MODE_RELOAD = 2'b10;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             state_q, state_d;

  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] stepped;
  logic             at_term;
  logic             step;

  assign term    = dir ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  assign at_term = (count_q == term);
  assign stepped = dir ? (count_q + ONE) : (count_q - ONE);
  assign step    = en & ~load_en & (state_q == RUN);

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    state_d  = state_q;
    if (load_en) begin
      count_d  = data;
      reload_d = data;
      state_d  = RUN;
    end else if (step) begin
      if (!at_term) begin
        count_d = stepped;
        tc_d    = (stepped == term);
      end else begin
        case (mode)
          MODE_WRAP: begin
            // Leaving the terminal by a modular step can never land back on it.
            count_d = stepped;
          end
          MODE_RELOAD: begin
            count_d = reload_q;
            tc_d    = (reload_q == term);
          end
          default: begin
            state_d = DONE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      state_q  <= RUN;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      state_q  <= state_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign done  = (state_q == DONE);

endmodule
